// File: rtl/adc_iq_capture_packer.sv
// I/Q ADC capture: synchronises adc_clk edges into clk, packs samples LSB-first into RAM words.
// Optional Q channel built only when IQ_Q_CHANNEL_EN is defined; otherwise mem_din_q is 0.
module adc_iq_capture_packer #(
  parameter int SAMPLE_W    = 1,
  parameter int WORD_W      = 8,
  parameter int ADDR_W      = 14,
  parameter int SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                adc_clk,
  input  logic [SAMPLE_W-1:0] i_in,
  input  logic [SAMPLE_W-1:0] q_in,
  input  logic                start,
  input  logic                abort,
  input  logic [ADDR_W:0]     len_words,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [WORD_W-1:0]   mem_din_i,
  output logic [WORD_W-1:0]   mem_din_q,
  output logic                busy,
  output logic                done,
  output logic [ADDR_W:0]     words_written
);

  localparam int SPW   = WORD_W / SAMPLE_W;
  localparam int CNT_W = (SPW > 1) ? $clog2(SPW) : 1;
  localparam int PIPE_W = SYNC_STAGES * SAMPLE_W;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SPW - 1);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ARM     = 2'd1;
  localparam logic [1:0] ST_CAPTURE = 2'd2;

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   hist_q, hist_d;
  logic [PIPE_W-1:0]      i_pipe_q, i_pipe_d;
  logic [1:0]             state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [ADDR_W:0]        len_q, len_d;
  logic [ADDR_W:0]        ww_q, ww_d;
  logic [ADDR_W-1:0]      addr_q, addr_d;
  logic [WORD_W-1:0]      shadow_i_q, shadow_i_d, shadow_i_new;
  logic [WORD_W-1:0]      din_i_q, din_i_d;
  logic                   we_q, we_d;
  logic                   done_q, done_d;
  logic                   adc_edge;
  logic                   accept;
  logic                   word_done;
  logic [SAMPLE_W-1:0]    i_s;

  // Data rides a pipeline as deep as the clock synchroniser so it lines up with adc_edge.
  always_comb begin
    sync_d   = {sync_q[SYNC_STAGES-2:0], adc_clk};
    hist_d   = sync_q[SYNC_STAGES-1];
    i_pipe_d = {i_pipe_q[PIPE_W-SAMPLE_W-1:0], i_in};
  end

  assign adc_edge  = sync_q[SYNC_STAGES-1] & ~hist_q;
  assign i_s       = i_pipe_q[PIPE_W-1 -: SAMPLE_W];
  assign word_done = accept & (cnt_q == CNT_LAST);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    ww_d    = ww_q;
    addr_d  = addr_q;
    done_d  = 1'b0;
    accept  = 1'b0;
    if (we_q) begin
      addr_d = addr_q + 1'b1;
      ww_d   = ww_q + 1'b1;
    end
    if (abort) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            if (len_words == '0) begin
              done_d = 1'b1;
            end else begin
              len_d   = len_words;
              ww_d    = '0;
              addr_d  = '0;
              cnt_d   = '0;
              state_d = ST_ARM;
            end
          end
        end
        ST_ARM: begin
          if (adc_edge) begin
            accept  = 1'b1;
            state_d = ST_CAPTURE;
          end
        end
        ST_CAPTURE: begin
          if (we_q && ((ww_q + 1'b1) == len_q)) begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end else if (adc_edge) begin
            accept = 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
    if (accept) begin
      cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
    end
  end

  always_comb begin
    shadow_i_new = shadow_i_q;
    shadow_i_new[int'(cnt_q) * SAMPLE_W +: SAMPLE_W] = i_s;
    shadow_i_d = accept ? shadow_i_new : shadow_i_q;
    din_i_d    = word_done ? shadow_i_new : din_i_q;
    we_d       = word_done;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q     <= '0;
      hist_q     <= 1'b0;
      i_pipe_q   <= '0;
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      len_q      <= '0;
      ww_q       <= '0;
      addr_q     <= '0;
      shadow_i_q <= '0;
      din_i_q    <= '0;
      we_q       <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      sync_q     <= sync_d;
      hist_q     <= hist_d;
      i_pipe_q   <= i_pipe_d;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      len_q      <= len_d;
      ww_q       <= ww_d;
      addr_q     <= addr_d;
      shadow_i_q <= shadow_i_d;
      din_i_q    <= din_i_d;
      we_q       <= we_d;
      done_q     <= done_d;
    end
  end

`ifdef IQ_Q_CHANNEL_EN
  logic [PIPE_W-1:0]   q_pipe_q, q_pipe_d;
  logic [WORD_W-1:0]   shadow_q_q, shadow_q_d, shadow_q_new;
  logic [WORD_W-1:0]   din_q_q, din_q_d;
  logic [SAMPLE_W-1:0] q_s;

  assign q_s = q_pipe_q[PIPE_W-1 -: SAMPLE_W];

  always_comb begin
    q_pipe_d     = {q_pipe_q[PIPE_W-SAMPLE_W-1:0], q_in};
    shadow_q_new = shadow_q_q;
    shadow_q_new[int'(cnt_q) * SAMPLE_W +: SAMPLE_W] = q_s;
    shadow_q_d   = accept ? shadow_q_new : shadow_q_q;
    din_q_d      = word_done ? shadow_q_new : din_q_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_pipe_q   <= '0;
      shadow_q_q <= '0;
      din_q_q    <= '0;
    end else begin
      q_pipe_q   <= q_pipe_d;
      shadow_q_q <= shadow_q_d;
      din_q_q    <= din_q_d;
    end
  end

  assign mem_din_q = din_q_q;
`else
  logic unused_q;
  assign unused_q  = ^q_in;
  assign mem_din_q = '0;
`endif

  assign mem_we        = we_q;
  assign mem_addr      = addr_q;
  assign mem_din_i     = din_i_q;
  assign busy          = (state_q != ST_IDLE);
  assign done          = done_q;
  assign words_written = ww_q;

endmodule

// File: doc/adc_iq_capture_packer.md
# adc_iq_capture_packer

Parametrised capture front end for the GNSS acquisition path. Samples I/Q ADC data at each rising edge of the slow `adc_clk` (treated as data, synchronised into `clk`), packs `WORD_W/SAMPLE_W` consecutive samples per channel into one word LSB-first, and issues one-cycle write strobes with an incrementing address to the per-channel block RAMs. A capture is armed by `start`, runs for a programmed number of words, then signals `done`.

## Interface
- `SAMPLE_W`, 1, bits per I (and Q) sample.
- `WORD_W`, 8, RAM word width; must be an integer multiple of `SAMPLE_W`.
- `ADDR_W`, 14, RAM address width.
- `SYNC_STAGES`, 2, flops in the `adc_clk` synchroniser; minimum 2.
- `clk` input 1: single system clock; all logic is on its rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `adc_clk` input 1: ADC sample clock, asynchronous to `clk`, sampled as data.
- `i_in` input SAMPLE_W: I sample, stable around `adc_clk` rising edge.
- `q_in` input SAMPLE_W: Q sample, same timing as `i_in`.
- `start` input 1: one-cycle arm request; honoured only in IDLE.
- `abort` input 1: terminate capture immediately.
- `len_words` input ADDR_W+1: words to capture; sampled at `start`.
- `mem_we` output 1: write strobe, one `clk` cycle per completed word.
- `mem_addr` output ADDR_W: write address.
- `mem_din_i` output WORD_W: packed I word.
- `mem_din_q` output WORD_W: packed Q word.
- `busy` output 1: high in ARM and CAPTURE.
- `done` output 1: one-cycle pulse on normal completion.
- `words_written` output ADDR_W+1: words written in current/last capture.

## Operation
- SPW = WORD_W/SAMPLE_W. Sample counter is clog2(SPW) bits wide (min 1).
- Synchroniser: `adc_clk` passes through SYNC_STAGES flops plus one history flop; `adc_edge` = synced high and history low. `i_in`/`q_in` are registered through the same number of stages so they stay aligned with `adc_edge`.
- States: IDLE, ARM, CAPTURE.
  - IDLE: `start`=1 with `len_words`=0 → stays IDLE, `done` pulses next cycle, no writes. `start`=1 with `len_words`≠0 → latch length, clear `words_written`, `mem_addr`, sample counter → ARM.
  - ARM → CAPTURE on the first `adc_edge`; that sample is accepted (sample 0).
  - CAPTURE: each `adc_edge` places the sample in bits [(n+1)·SAMPLE_W-1 : n·SAMPLE_W] of the shadow word, n = sample counter. On n = SPW-1 the full word is copied to `mem_din_*`, `mem_we`=1, counter wraps to 0. After the strobe cycle `mem_addr` and `words_written` increment. When `words_written` reaches the latched length → `done` pulse, → IDLE.
- `mem_addr` wraps modulo 2^ADDR_W; the maximum length is 2^ADDR_W words.
- `abort` (any state) → IDLE next cycle; partial word discarded, no strobe, no `done`; `words_written` holds its value. `abort` beats `start` in the same cycle.
- `start` while busy: ignored.
- `rst` (asynchronous, including mid-capture) forces IDLE; all outputs, counters, and synchroniser flops go to 0.

## Timing
- Reset values: `mem_we`=0, `mem_addr`=0, `mem_din_i`=0, `mem_din_q`=0, `busy`=0, `done`=0, `words_written`=0.
- `adc_clk` rising edge to `adc_edge`: SYNC_STAGES+1 `clk` cycles (±1 for metastability).
- Final `adc_edge` of a word → `mem_we` high on the next `clk` edge, for exactly 1 cycle; `mem_addr`/`mem_din_*` valid during that cycle.
- `done` asserts on the cycle after the last `mem_we`; `busy` falls on the same cycle.
- `start` → `busy` high the next cycle.
- Requirement: `adc_clk` high and low phases each ≥ SYNC_STAGES+1 `clk` periods. A violation drops samples silently.

## Configuration
- `IQ_Q_CHANNEL_EN` defined: Q path built exactly as described.
- Not defined: Q synchroniser and packer are omitted, `mem_din_q` is tied to 0, and `q_in` is unused. I behaviour and timing are unchanged.

## Test plan
- SAMPLE_W=1, WORD_W=8, `len_words`=4, I pattern 1,0,1,1,0,0,0,1 repeating → 4 strobes, addr 0..3, `mem_din_i`=8'h8D each, `done` once, `words_written`=4.
- SAMPLE_W=2, WORD_W=8, `len_words`=2, I samples 0,1,2,3,3,2,1,0 → `mem_din_i` = 8'hE4 then 8'h1B.
- `abort` after 3 samples of word 1 (len 4) → exactly one strobe, no `done`, `busy`=0, `words_written`=1.
- `len_words`=0 with `start` → `done` one cycle later, `mem_we` never asserts. `start` during capture → no effect on length or address.
- `rst` pulsed mid-word → all outputs 0 immediately. A new `start` then restarts at address 0 with counter 0.
- ADDR_W=3, `len_words`=8 → addresses 0..7, last strobe at addr 7, `done`. Without `IQ_Q_CHANNEL_EN`, `mem_din_q`=0 throughout.
